// File: rtl/fp_sqrt_pkg.sv
// Shared constants, FSM encoding and decoded-operand record for the fp_sqrt issue stage.
package fp_sqrt_pkg;

    localparam int D_M_SIZE   = 53;
    localparam int D_EXP_SIZE = 11;
    localparam int S_M_SIZE   = 24;
    localparam int S_EXP_SIZE = 8;

    localparam logic [2:0] FLAG_DENORM   = 3'b000;
    localparam logic [2:0] FLAG_ZERO     = 3'b001;
    localparam logic [2:0] FLAG_INF      = 3'b010;
    localparam logic [2:0] FLAG_NAN      = 3'b011;
    localparam logic [2:0] FLAG_NORMAL   = 3'b100;
    localparam logic [2:0] FLAG_SIGN_ERR = 3'b111;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;

    typedef struct packed {
        logic [D_M_SIZE-1:0]   mant;
        logic [D_EXP_SIZE-1:0] exp;
        logic                  sign;
        logic                  typ;
        logic [2:0]            flags;
    } op_rec_t;

endpackage

// File: rtl/fp_sqrt_issue_if.sv
// Operand-side and fp_sqrt-side signals of the issue stage, bundled with direction views.
interface fp_sqrt_issue_if #(
    parameter int M_SIZE   = 53,
    parameter int EXP_SIZE = 11
);
    // Operand handshake: a transfer happens on a rising edge where op_valid && op_ready;
    // op_bits/op_type must be stable while op_valid is high, and op_ready never depends
    // combinationally on op_valid.
    logic                op_valid;
    logic                op_ready;
    logic [63:0]         op_bits;
    logic                op_type;
    logic [M_SIZE-1:0]   sqrt_mantisa;
    logic [EXP_SIZE-1:0] sqrt_exp;
    logic                sqrt_sign;
    logic                sqrt_type;
    logic [2:0]          sqrt_flags;
    logic                sqrt_start;
    logic                sqrt_ready;
    logic                op_done;
    logic                busy;

    modport slave (
        input  op_valid, op_bits, op_type, sqrt_ready,
        output op_ready, sqrt_mantisa, sqrt_exp, sqrt_sign, sqrt_type, sqrt_flags,
               sqrt_start, op_done, busy
    );

    modport master (
        output op_valid, op_bits, op_type, sqrt_ready,
        input  op_ready, sqrt_mantisa, sqrt_exp, sqrt_sign, sqrt_type, sqrt_flags,
               sqrt_start, op_done, busy
    );
endinterface

// File: rtl/fp_sqrt_op_fifo.sv
// Two-entry register FIFO holding decoded operands awaiting issue.
module fp_sqrt_op_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= !wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= !rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end
endmodule

// File: rtl/fp_sqrt_issue.sv
// Issue stage for fp_sqrt: decodes raw IEEE operands, buffers two, and sequences one op at a time.
module fp_sqrt_issue
    import fp_sqrt_pkg::*;
#(
    parameter int M_SIZE   = 53,
    parameter int EXP_SIZE = 11
) (
    input  logic   clk,
    input  logic   rst,
    fp_sqrt_issue_if.slave bus,
    output state_t dbg_state
);
    function automatic op_rec_t decode(input logic [63:0] b, input logic typ);
        op_rec_t                r;
        logic [D_EXP_SIZE-1:0]  e;
        logic [D_M_SIZE-2:0]    f;
        logic [D_M_SIZE-1:0]    hid;
        logic                   e_max;
        if (typ) begin
            r.sign = b[63];
            e      = b[62:52];
            f      = b[51:0];
            e_max  = &b[62:52];
            hid    = D_M_SIZE'(1) << (D_M_SIZE - 1);
        end else begin
            r.sign = b[31];
            e      = {3'b000, b[30:23]};
            f      = {29'd0, b[22:0]};
            e_max  = &b[30:23];
            hid    = D_M_SIZE'(1) << (S_M_SIZE - 1);
        end
        r.exp  = e;
        r.typ  = typ;
        r.mant = {1'b0, f};
        if (e == '0) begin
            r.flags = (f == '0) ? FLAG_ZERO : FLAG_DENORM;
        end else if (e_max) begin
            r.flags = (f == '0) ? FLAG_INF : FLAG_NAN;
        end else begin
            r.flags = FLAG_NORMAL;
            r.mant  = hid | {1'b0, f};
        end
        // Negative zero and NaN keep their own class; every other negative is illegal.
        if (r.sign && (r.flags == FLAG_DENORM || r.flags == FLAG_INF || r.flags == FLAG_NORMAL)) begin
            r.flags = FLAG_SIGN_ERR;
        end
        return r;
    endfunction

    op_rec_t             in_rec;
    op_rec_t             head;
    op_rec_t             load_rec;
    state_t              state;
    logic                accept, bypass, fifo_push, fifo_pop;
    logic                fifo_full, fifo_empty;
    logic [1:0]          fifo_count, count_next;
    logic                ready_q, seen_low;
    logic [M_SIZE-1:0]   mant_q;
    logic [EXP_SIZE-1:0] exp_q;
    logic                sign_q, type_q;
    logic [2:0]          flags_q;

    assign in_rec     = decode(bus.op_bits, bus.op_type);
    assign accept     = bus.op_valid && ready_q;
    // An operand arriving at an idle, empty stage skips the FIFO so it issues on the next edge.
    assign bypass     = (state == ST_IDLE) && fifo_empty && accept;
    assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
    assign fifo_push  = accept && !bypass && !fifo_full;
    assign load_rec   = fifo_empty ? in_rec : head;
    assign count_next = fifo_count + 2'(fifo_push) - 2'(fifo_pop);

    fp_sqrt_op_fifo #(.W($bits(op_rec_t))) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (in_rec),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            seen_low <= 1'b0;
            ready_q  <= 1'b0;
            mant_q   <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            type_q   <= 1'b0;
            flags_q  <= 3'b000;
        end else begin
            ready_q <= (count_next != 2'd2);
            case (state)
                ST_IDLE: begin
                    if (fifo_pop || bypass) begin
                        mant_q  <= M_SIZE'(load_rec.mant);
                        exp_q   <= EXP_SIZE'(load_rec.exp);
                        sign_q  <= load_rec.sign;
                        type_q  <= load_rec.typ;
                        flags_q <= load_rec.flags;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    seen_low <= 1'b0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A ready level carried over from the previous op must drop before it counts.
                    if (!bus.sqrt_ready) begin
                        seen_low <= 1'b1;
                    end else if (seen_low) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.op_ready     = ready_q;
    assign bus.sqrt_mantisa = mant_q;
    assign bus.sqrt_exp     = exp_q;
    assign bus.sqrt_sign    = sign_q;
    assign bus.sqrt_type    = type_q;
    assign bus.sqrt_flags   = flags_q;
    assign bus.sqrt_start   = (state == ST_START);
    assign bus.op_done      = (state == ST_WAIT) && bus.sqrt_ready && seen_low;
    assign bus.busy         = !fifo_empty || (state != ST_IDLE);
    assign dbg_state        = state;
endmodule
